// File: rtl/pfx_pkg.sv
// Shared definitions for the prefix-sum family (pfxsum / pfx_diff):
// FSM state encoding, default geometry and the element-slice helper.
package pfx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pfx_state_e;

  localparam int PFX_IWIDTH = 8;
  localparam int PFX_V_LEN  = 8;
  localparam int PFX_LANES  = 2;

  // Low bit of element idx in a vector packed as element i at [i*width +: width].
  function automatic int pfx_elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pfx_diff_lane.sv
// One differencing lane: combinational subtractor, wraps modulo 2^IWIDTH.
module pfx_diff_lane #(
  parameter int IWIDTH = 8
) (
  input  logic [IWIDTH-1:0] a,
  input  logic [IWIDTH-1:0] b,
  output logic [IWIDTH-1:0] d
);

  assign d = a - b;

endmodule

// File: rtl/pfx_diff.sv
// Prefix-sum inverter: ovec[0] = ivec[0], ovec[i] = ivec[i] - ivec[i-1], LANES elements per cycle.
// Optional macro PFX_DIFF_OUTREG_EN adds one output register stage on ovec/valid_out.
module pfx_diff
  import pfx_pkg::*;
#(
  parameter int IWIDTH = PFX_IWIDTH,
  parameter int V_LEN  = PFX_V_LEN,
  parameter int LANES  = PFX_LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [IWIDTH*V_LEN-1:0] ivec,
  output logic                    valid_out,
  output logic [IWIDTH*V_LEN-1:0] ovec
);

  localparam int NSTEP = (LANES > 0) ? V_LEN / LANES : 1;
  localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int EW    = $clog2(V_LEN) + 1;
  localparam int VW    = IWIDTH * V_LEN;

  if (LANES < 1) begin : g_bad_lanes
    $error("pfx_diff: LANES must be at least 1");
  end else if (V_LEN % LANES != 0) begin : g_bad_split
    $error("pfx_diff: V_LEN must be a multiple of LANES");
  end

  pfx_state_e        state_reg, state_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic [VW-1:0]     cap_reg, cap_next;
  logic [VW-1:0]     ovec_reg, ovec_next;
  logic              valid_reg, valid_next;

  logic [IWIDTH-1:0] cur_elem  [LANES];
  logic [IWIDTH-1:0] prev_elem [LANES];
  logic [IWIDTH-1:0] diff_elem [LANES];
  logic [EW-1:0]     elem_idx  [LANES];
  logic [EW-1:0]     prev_idx  [LANES];

  // Every operand comes from the captured copy, including the neighbour across a lane-group edge.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign elem_idx[gi]  = EW'(idx_reg) * EW'(LANES) + EW'(gi);
    assign prev_idx[gi]  = (elem_idx[gi] == '0) ? '0 : elem_idx[gi] - EW'(1);
    assign cur_elem[gi]  = cap_reg[pfx_elem_lsb(int'(elem_idx[gi]), IWIDTH) +: IWIDTH];
    assign prev_elem[gi] = (elem_idx[gi] == '0) ? '0 :
                           cap_reg[pfx_elem_lsb(int'(prev_idx[gi]), IWIDTH) +: IWIDTH];

    pfx_diff_lane #(.IWIDTH(IWIDTH)) u_lane (
      .a (cur_elem[gi]),
      .b (prev_elem[gi]),
      .d (diff_elem[gi])
    );
  end

  always_comb begin
    ovec_next = ovec_reg;
    if (state_reg == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        ovec_next[pfx_elem_lsb(int'(elem_idx[l]), IWIDTH) +: IWIDTH] = diff_elem[l];
      end
    end
  end

`ifdef PFX_DIFF_OUTREG_EN
  // DONE lasts two cycles so ready_in waits for the extra output stage.
  logic hold_reg, hold_next;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cap_next   = cap_reg;
    valid_next = 1'b0;
`ifdef PFX_DIFF_OUTREG_EN
    hold_next  = hold_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          cap_next   = ivec;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx_reg == IDXW'(NSTEP - 1)) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + IDXW'(1);
        end
      end
      DONE: begin
`ifdef PFX_DIFF_OUTREG_EN
        if (!hold_reg) begin
          valid_next = 1'b1;
          hold_next  = 1'b1;
        end else begin
          hold_next  = 1'b0;
          state_next = IDLE;
        end
`else
        valid_next = 1'b1;
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cap_reg   <= '0;
      ovec_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cap_reg   <= cap_next;
      ovec_reg  <= ovec_next;
      valid_reg <= valid_next;
    end
  end

  assign ready_in = (state_reg == IDLE);

`ifdef PFX_DIFF_OUTREG_EN
  logic [VW-1:0] ovec_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 1'b0;
      ovec_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      ovec_q   <= ovec_reg;
      valid_q  <= valid_reg;
    end
  end

  assign ovec      = ovec_q;
  assign valid_out = valid_q;
`else
  assign ovec      = ovec_reg;
  assign valid_out = valid_reg;
`endif

endmodule

// File: tb/tb_pfx_diff.sv
// Directed bench for pfx_diff: LANES=2 main instance plus LANES=1/4/8 variants on shared inputs.
module tb_pfx_diff;

`ifdef PFX_DIFF_OUTREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [63:0] VEC_A  = 64'h241C150F0A060301;
  localparam logic [63:0] EXP_A  = 64'h0807060504030201;
  localparam logic [63:0] VEC_B  = 64'h0102030405060708;
  localparam logic [63:0] EXP_B  = 64'hFFFFFFFFFFFFFF08;
  localparam logic [63:0] VEC_W  = 64'h05050505050500FF;
  localparam logic [63:0] EXP_W  = 64'h00000000000501FF;
  localparam logic [63:0] VEC_C  = 64'h0807060504030201;
  localparam logic [63:0] EXP_C  = 64'h0101010101010101;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [63:0] ivec;
  logic        rdy [4];
  logic        vo  [4];
  logic [63:0] ov  [4];

  int checks;
  int errors;
  int exp_lat [4];
  int lat_m   [4];
  int pulses_m[4];
  logic [63:0] res_m [4];

  pfx_diff #(.IWIDTH(8), .V_LEN(8), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(rdy[0]),
    .ivec(ivec), .valid_out(vo[0]), .ovec(ov[0]));
  pfx_diff #(.IWIDTH(8), .V_LEN(8), .LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(rdy[1]),
    .ivec(ivec), .valid_out(vo[1]), .ovec(ov[1]));
  pfx_diff #(.IWIDTH(8), .V_LEN(8), .LANES(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(rdy[2]),
    .ivec(ivec), .valid_out(vo[2]), .ovec(ov[2]));
  pfx_diff #(.IWIDTH(8), .V_LEN(8), .LANES(8)) dut_l8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(rdy[3]),
    .ivec(ivec), .valid_out(vo[3]), .ovec(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_all_idle();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2] && rdy[3]) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(rdy[0] && rdy[1] && rdy[2] && rdy[3])) begin
      errors++;
      $display("FAIL idle_timeout ready=%b%b%b%b required 1111", rdy[3], rdy[2], rdy[1], rdy[0]);
    end
  endtask

  // Accept v, scramble ivec afterwards, optionally pulse valid_in with bv after cycle busy_at.
  task automatic run_vec(input logic [63:0] v, input int busy_at, input logic [63:0] bv);
    wait_all_idle();
    for (int k = 0; k < 4; k++) begin
      lat_m[k] = -1; res_m[k] = '0; pulses_m[k] = 0;
    end
    ivec = v; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; ivec = ~v;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (vo[k]) begin
          pulses_m[k]++;
          if (lat_m[k] < 0) begin
            lat_m[k] = c;
            res_m[k] = ov[k];
          end
        end
      end
      if (c == busy_at) begin
        valid_in = 1'b1; ivec = bv;
      end else if (c == busy_at + 1) begin
        valid_in = 1'b0;
      end
    end
    $display("txn ivec=%h ovec=%h latency=%0d pulses=%0d", v, res_m[0], lat_m[0], pulses_m[0]);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid_in = 1'b0; ivec = '0;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy[0]); end
    checks++; if (vo[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vo[0]); end
    checks++; if (ov[0] !== 64'h0) begin errors++; $display("FAIL reset_ovec got=%h exp=0", ov[0]); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_vec(VEC_A, -1, '0);
    checks++; if (res_m[0] !== EXP_A) begin errors++; $display("FAIL basic_ovec got=%h exp=%h", res_m[0], EXP_A); end
    checks++; if (lat_m[0] !== exp_lat[0]) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat_m[0], exp_lat[0]); end
    checks++; if (pulses_m[0] !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses_m[0]); end
  endtask

  task automatic test_variants();
    run_vec(VEC_A, -1, '0);
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (res_m[k] !== EXP_A) begin errors++; $display("FAIL variant%0d_ovec got=%h exp=%h", k, res_m[k], EXP_A); end
      checks++;
      if (lat_m[k] !== exp_lat[k]) begin errors++; $display("FAIL variant%0d_latency got=%0d exp=%0d", k, lat_m[k], exp_lat[k]); end
      checks++;
      if (pulses_m[k] !== 1) begin errors++; $display("FAIL variant%0d_pulses got=%0d exp=1", k, pulses_m[k]); end
    end
  endtask

  task automatic test_wrap();
    run_vec(VEC_W, -1, '0);
    checks++; if (res_m[0] !== EXP_W) begin errors++; $display("FAIL wrap_ovec got=%h exp=%h", res_m[0], EXP_W); end
    checks++; if (res_m[3] !== EXP_W) begin errors++; $display("FAIL wrap_ovec_l8 got=%h exp=%h", res_m[3], EXP_W); end
  endtask

  task automatic test_busy();
    run_vec(VEC_A, 1, VEC_B);
    checks++; if (pulses_m[0] !== 1) begin errors++; $display("FAIL busy_pulses got=%0d exp=1", pulses_m[0]); end
    checks++; if (res_m[0] !== EXP_A) begin errors++; $display("FAIL busy_ovec got=%h exp=%h", res_m[0], EXP_A); end
  endtask

  task automatic test_reset_mid();
    int npulse;
    wait_all_idle();
    ivec = VEC_A; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ov[0] !== 64'h0) begin errors++; $display("FAIL midrst_ovec got=%h exp=0", ov[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", rdy[0]); end
    checks++; if (vo[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", vo[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (vo[0]) npulse++;
    end
    checks++; if (npulse !== 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", npulse); end
    $display("txn reset-abort ivec=%h pulses=%0d", VEC_A, npulse);
    run_vec(VEC_C, -1, '0);
    checks++; if (res_m[0] !== EXP_C) begin errors++; $display("FAIL midrst_next_ovec got=%h exp=%h", res_m[0], EXP_C); end
    checks++; if (lat_m[0] !== exp_lat[0]) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=%0d", lat_m[0], exp_lat[0]); end
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    logic [63:0] r1, r2;
    wait_all_idle();
    p1 = -1; p2 = -1; r1 = '0; r2 = '0;
    ivec = VEC_A; valid_in = 1'b1;
    @(posedge clk); #1;
    ivec = VEC_B;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (vo[0]) begin
        if (p1 < 0) begin p1 = c; r1 = ov[0]; end
        else if (p2 < 0) begin p2 = c; r2 = ov[0]; end
      end
    end
    valid_in = 1'b0;
    $display("txn back-to-back first=%0d:%h second=%0d:%h", p1, r1, p2, r2);
    checks++; if (p1 !== exp_lat[0]) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", p1, exp_lat[0]); end
    checks++; if (r1 !== EXP_A) begin errors++; $display("FAIL b2b_first_ovec got=%h exp=%h", r1, EXP_A); end
    checks++; if (p2 !== 2 * exp_lat[0] + 1) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", p2, 2 * exp_lat[0] + 1); end
    checks++; if (r2 !== EXP_B) begin errors++; $display("FAIL b2b_second_ovec got=%h exp=%h", r2, EXP_B); end
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic test_round_trip();
    logic [63:0] x, p;
    logic [7:0]  acc;
    for (int n = 0; n < 100; n++) begin
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        x[i*8 +: 8] = 8'($urandom);
        acc = acc + x[i*8 +: 8];
        p[i*8 +: 8] = acc;
      end
      run_vec(p, -1, '0);
      checks++;
      if (res_m[0] !== x) begin errors++; $display("FAIL roundtrip%0d got=%h exp=%h", n, res_m[0], x); end
      checks++;
      if (res_m[1] !== x || res_m[2] !== x || res_m[3] !== x) begin
        errors++;
        $display("FAIL roundtrip%0d_variants got=%h/%h/%h exp=%h", n, res_m[1], res_m[2], res_m[3], x);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_lat[0] = 5 + EXTRA;
    exp_lat[1] = 9 + EXTRA;
    exp_lat[2] = 3 + EXTRA;
    exp_lat[3] = 2 + EXTRA;
    test_reset();
    test_basic();
    test_variants();
    test_wrap();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
